// File: rtl/sumrest_nibble_seq.sv
// Nibble-serial add/subtract controller: one 4-bit slice is reused across NIBBLES
// clock cycles, LS nibble first, with the inter-nibble carry held in a register.
module sumrest_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sign,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [IW-1:0]  idx;
  logic           carry;
  logic           sub;
  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic [3:0]     nib_a;
  logic [3:0]     nib_b;
  logic [4:0]     slice_sum;
  logic           last_nibble;
  logic [W-1:0]   result_next;

  // Operands shift right each CALC cycle, so the active nibble is always bits [3:0];
  // on the last nibble bit 3 is therefore the operand sign bit used for overflow.
  assign nib_a       = a_sh[3:0];
  assign nib_b       = b_sh[3:0] ^ {4{sub}};
  assign slice_sum   = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry};
  assign last_nibble = (idx == IW'(NIBBLES - 1));

  always_comb begin
    result_next = result;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx == IW'(n)) begin
        result_next[n*4 +: 4] = slice_sum[3:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_nibble) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they track the FSM without
  // any combinational path from the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      sub    <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            sub   <= sign;
            carry <= sign;
            idx   <= '0;
          end
        end
        CALC: begin
          result <= result_next;
          carry  <= slice_sum[4];
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          idx    <= idx + IW'(1);
          if (last_nibble) begin
            cout <= slice_sum[4];
            ovf  <= (nib_a[3] == nib_b[3]) && (slice_sum[3] != nib_a[3]);
            idx  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sumrest_nibble_seq.sv
// Self-checking bench for sumrest_nibble_seq: directed cases, random operations,
// start-while-busy, mid-operation reset and back-to-back starts against an integer model.
module tb_sumrest_nibble_seq;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sign;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int vectorCount   = 0;
  int miscompareCnt = 0;

  sumrest_nibble_seq #(.NIBBLES(NIB)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sign   (sign),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  task automatic modelOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] r, output logic c, output logic v);
    longint ua, ub, sa, sb, sr, ur;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    if (s) begin
      ur = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      ur = ua + ub;
      c  = (ur > 65535);
      sr = sa + sb;
    end
    r = W'(ur & 65535);
    v = (sr > 32767) || (sr < -32768);
  endtask

  // Runs one operation; interfereAt 1..NIB raises start during that CALC edge,
  // NIB+1 raises it during DONE, 0 means no interference.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                               input int interfereAt);
    logic [W-1:0] expR;
    logic         expC, expV;
    modelOp(a, b, s, expR, expC, expV);
    @(negedge clk);
    A = a; B = b; sign = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); sign = ~s;
    checkOutput("busy_rise", {31'b0, busy}, 32'd1);
    checkOutput("done_early", {31'b0, done}, 32'd0);
    for (int i = 1; i <= NIB; i++) begin
      if (i == interfereAt) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("done_timing", {31'b0, done}, (i == NIB) ? 32'd1 : 32'd0);
      checkOutput("busy_calc", {31'b0, busy}, 32'd1);
    end
    checkOutput("result", {16'b0, result}, {16'b0, expR});
    checkOutput("cout", {31'b0, cout}, {31'b0, expC});
    checkOutput("ovf", {31'b0, ovf}, {31'b0, expV});
    if (interfereAt == NIB + 1) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_fall", {31'b0, busy}, 32'd0);
    checkOutput("done_pulse", {31'b0, done}, 32'd0);
    checkOutput("result_hold", {16'b0, result}, {16'b0, expR});
  endtask

  initial begin
    logic [W-1:0] ra, rb, expR;
    logic         rs, expC, expV;
    rst = 1'b1; start = 1'b0; sign = 1'b0; A = '0; B = '0;
    #12;
    checkOutput("rst_result", {16'b0, result}, 32'd0);
    checkOutput("rst_flags", {29'b0, busy, done, cout | ovf}, 32'd0);
    @(negedge clk); rst = 1'b0;

    applyStimulus(16'h1234, 16'h0FCD, 1'b0, 0);
    applyStimulus(16'h0005, 16'h0007, 1'b1, 0);
    applyStimulus(16'h0007, 16'h0005, 1'b1, 0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 0);
    applyStimulus(16'h8000, 16'h0001, 1'b1, 0);
    applyStimulus(16'h4321, 16'h1111, 1'b0, 2);
    applyStimulus(16'hA5A5, 16'h5A5A, 1'b1, NIB + 1);

    // Reset during the second CALC cycle clears everything without a clock edge.
    @(negedge clk);
    A = 16'h1111; B = 16'h2222; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_result", {16'b0, result}, 32'd0);
    checkOutput("midrst_flags", {29'b0, busy, done, cout | ovf}, 32'd0);
    @(negedge clk); rst = 1'b0;
    applyStimulus(16'h9ABC, 16'h1357, 1'b1, 0);

    for (int n = 0; n < 20; n++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, NIB + 1)));
    end

    // Start held high: accept edge is cycle 0, done follows 4 edges later, repeat every 6.
    ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom_range(0, 1));
    modelOp(ra, rb, rs, expR, expC, expV);
    @(negedge clk);
    A = ra; B = rb; sign = rs; start = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      checkOutput("b2b_done", {31'b0, done}, ((c % 6) == 4) ? 32'd1 : 32'd0);
      if ((c % 6) == 4) begin
        checkOutput("b2b_result", {16'b0, result}, {16'b0, expR});
        checkOutput("b2b_cout", {31'b0, cout}, {31'b0, expC});
      end
    end
    start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCnt);
    $finish;
  end

endmodule
